// File: rtl/pic_pkg.sv
// Shared types and defaults for the PIC interrupt arbiter.
package pic_pkg;

  typedef enum logic [1:0] {
    PIC_IDLE    = 2'd0,
    PIC_OFFER   = 2'd1,
    PIC_SERVICE = 2'd2
  } pic_state_e;

  localparam int PIC_PRIO_W = 3;

endpackage

// File: rtl/pic_rr_select.sv
// Rotating find-first-one: grants the first set request at or after ptr+1,
// wrapping at WIDTH-1 (explicit compare, so non-power-of-2 widths work).
module pic_rr_select #(
  parameter int WIDTH = 32,
  localparam int IDW = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic [WIDTH-1:0] req,
  input  logic [IDW-1:0]   ptr,
  output logic [IDW-1:0]   grant,
  output logic             any
);

  localparam logic [IDW-1:0] LAST = IDW'(WIDTH - 1);

  logic [IDW-1:0] idx;
  logic           found;

  // Walk the ring once starting just after the pointer; first hit wins.
  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = (ptr == LAST) ? '0 : ptr + 1'b1;
    for (int off = 0; off < WIDTH; off++) begin
      if (!found && req[idx]) begin
        grant = idx;
        found = 1'b1;
      end
      idx = (idx == LAST) ? '0 : idx + 1'b1;
    end
    any = found;
  end

endmodule

// File: rtl/pic_irq_arbiter.sv
// Interrupt arbiter: priority + threshold filtering, round-robin among equal
// priorities, valid/ready claim handshake and in-service tracking until EOI.
//
// state       | meaning
// PIC_IDLE    | arbitrating every cycle; registers a winner when one exists
// PIC_OFFER   | winner frozen on claim_*_o until the CPU accepts
// PIC_SERVICE | claimed irq awaiting its matching EOI; no new offers
module pic_irq_arbiter
  import pic_pkg::*;
#(
  parameter int NUM_IRQ = 32,
  parameter int PRIO_W  = PIC_PRIO_W,
  parameter int ID_W    = $clog2(NUM_IRQ)
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [NUM_IRQ-1:0]        irq_pending_i,
  input  logic [NUM_IRQ-1:0]        irq_enable_i,
  input  logic [NUM_IRQ*PRIO_W-1:0] irq_prio_i,
  input  logic [PRIO_W-1:0]         threshold_i,
  output logic                      claim_valid_o,
  output logic [ID_W-1:0]           claim_id_o,
  output logic [PRIO_W-1:0]         claim_prio_o,
  input  logic                      claim_ready_i,
  input  logic                      eoi_valid_i,
  input  logic [ID_W-1:0]           eoi_id_i,
  output logic                      in_service_o,
  output logic                      err_o
);

  pic_state_e         state, state_nxt;
  logic [NUM_IRQ-1:0] eligible;
  logic [NUM_IRQ-1:0] top_mask;
  logic [PRIO_W-1:0]  max_prio;
  logic [ID_W-1:0]    rr_ptr, rr_nxt;
  logic [ID_W-1:0]    win_id;
  logic               win_any;
  logic               valid_nxt;
  logic [ID_W-1:0]    id_nxt;
  logic [PRIO_W-1:0]  prio_nxt;
  logic               err_nxt;

  // Eligibility filter and unsigned max-priority reduction over eligible sources.
  always_comb begin
    eligible = '0;
    max_prio = '0;
    for (int n = 0; n < NUM_IRQ; n++) begin
      eligible[n] = irq_pending_i[n] && irq_enable_i[n] &&
                    (irq_prio_i[n*PRIO_W +: PRIO_W] > threshold_i);
      if (eligible[n] && (irq_prio_i[n*PRIO_W +: PRIO_W] > max_prio))
        max_prio = irq_prio_i[n*PRIO_W +: PRIO_W];
    end
  end

  // Only eligible sources sitting at the top priority compete in the ring.
  always_comb begin
    top_mask = '0;
    for (int n = 0; n < NUM_IRQ; n++)
      top_mask[n] = eligible[n] && (irq_prio_i[n*PRIO_W +: PRIO_W] == max_prio);
  end

  pic_rr_select #(.WIDTH(NUM_IRQ)) u_rr_select (
    .req   (top_mask),
    .ptr   (rr_ptr),
    .grant (win_id),
    .any   (win_any)
  );

  // Next-state and next-output decode; offers stay frozen outside IDLE.
  always_comb begin
    state_nxt = state;
    valid_nxt = claim_valid_o;
    id_nxt    = claim_id_o;
    prio_nxt  = claim_prio_o;
    rr_nxt    = rr_ptr;
    err_nxt   = 1'b0;
    case (state)
      PIC_IDLE: begin
        if (win_any) begin
          valid_nxt = 1'b1;
          id_nxt    = win_id;
          prio_nxt  = max_prio;
          state_nxt = PIC_OFFER;
        end
        err_nxt = eoi_valid_i;
      end
      PIC_OFFER: begin
        err_nxt = eoi_valid_i;
        if (claim_ready_i) begin
          rr_nxt    = claim_id_o;
          valid_nxt = 1'b0;
          state_nxt = PIC_SERVICE;
        end
      end
      PIC_SERVICE: begin
        if (eoi_valid_i) begin
          if (eoi_id_i == claim_id_o) state_nxt = PIC_IDLE;
          else                        err_nxt   = 1'b1;
        end
      end
      default: state_nxt = PIC_IDLE;
    endcase
  end

  // State and output registers; rr_ptr resets to the last id so id 0 wins the first tie.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state         <= PIC_IDLE;
      claim_valid_o <= 1'b0;
      claim_id_o    <= '0;
      claim_prio_o  <= '0;
      rr_ptr        <= ID_W'(NUM_IRQ - 1);
      err_o         <= 1'b0;
    end else begin
      state         <= state_nxt;
      claim_valid_o <= valid_nxt;
      claim_id_o    <= id_nxt;
      claim_prio_o  <= prio_nxt;
      rr_ptr        <= rr_nxt;
      err_o         <= err_nxt;
    end
  end

  assign in_service_o = (state == PIC_SERVICE);

endmodule

// File: tb/tb_pic_irq_arbiter.sv
// Self-checking bench for pic_irq_arbiter: directed scenarios plus a randomized
// claim/EOI loop checked against a priority/round-robin reference model.
module tb_pic_irq_arbiter;
  localparam int N  = 32;
  localparam int PW = 3;
  localparam int IW = 5;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic [N-1:0]  irq_pending_i;
  logic [N-1:0]  irq_enable_i;
  logic [N*PW-1:0] irq_prio_i;
  logic [PW-1:0] threshold_i;
  logic          claim_valid_o;
  logic [IW-1:0] claim_id_o;
  logic [PW-1:0] claim_prio_o;
  logic          claim_ready_i;
  logic          eoi_valid_i;
  logic [IW-1:0] eoi_id_i;
  logic          in_service_o;
  logic          err_o;

  int prio_arr[N];
  int tests = 0;
  int fails = 0;
  int model_rr;

  pic_irq_arbiter #(.NUM_IRQ(N), .PRIO_W(PW)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .irq_pending_i(irq_pending_i),
    .irq_enable_i(irq_enable_i), .irq_prio_i(irq_prio_i), .threshold_i(threshold_i),
    .claim_valid_o(claim_valid_o), .claim_id_o(claim_id_o), .claim_prio_o(claim_prio_o),
    .claim_ready_i(claim_ready_i), .eoi_valid_i(eoi_valid_i), .eoi_id_i(eoi_id_i),
    .in_service_o(in_service_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  always_comb begin
    irq_prio_i = '0;
    for (int n = 0; n < N; n++) irq_prio_i[n*PW +: PW] = PW'(prio_arr[n]);
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Reference: scan priorities from highest down, then ids in ring order after rr.
  task automatic model_winner(input int rr, output bit any, output int id, output int pr);
    any = 0; id = 0; pr = 0;
    for (int p = (1 << PW) - 1; p > int'(threshold_i) && !any; p--)
      for (int k = 1; k <= N && !any; k++) begin
        int c;
        c = (rr + k) % N;
        if (irq_pending_i[c] && irq_enable_i[c] && prio_arr[c] == p) begin
          any = 1; id = c; pr = p;
        end
      end
  endtask

  task automatic clear_inputs();
    irq_pending_i = '0; irq_enable_i = '1; threshold_i = '0;
    claim_ready_i = 0; eoi_valid_i = 0; eoi_id_i = '0;
    for (int n = 0; n < N; n++) prio_arr[n] = 0;
  endtask

  task automatic apply_reset();
    clear_inputs();
    rst_i = 1; tick(); tick(); rst_i = 0; #1;
    model_rr = N - 1;
  endtask

  task automatic do_claim();
    claim_ready_i = 1; tick(); claim_ready_i = 0;
    model_rr = int'(claim_id_o);
  endtask

  task automatic do_eoi(input int id);
    eoi_valid_i = 1; eoi_id_i = IW'(id); tick(); eoi_valid_i = 0;
  endtask

  task automatic check_offer(input string name, input int id, input int pr);
    tests++;
    if (claim_valid_o !== 1'b1 || int'(claim_id_o) !== id || int'(claim_prio_o) !== pr) begin
      fails++;
      $display("FAIL %s: got valid=%0b id=%0d prio=%0d, want valid=1 id=%0d prio=%0d",
               name, claim_valid_o, claim_id_o, claim_prio_o, id, pr);
    end
  endtask

  task automatic test_reset();
    rst_i = 1; clear_inputs(); #2;
    tests++;
    if (claim_valid_o !== 0 || claim_id_o !== 0 || claim_prio_o !== 0 ||
        in_service_o !== 0 || err_o !== 0) begin
      fails++;
      $display("FAIL reset_values: valid=%0b id=%0d prio=%0d insvc=%0b err=%0b, want all 0",
               claim_valid_o, claim_id_o, claim_prio_o, in_service_o, err_o);
    end
    apply_reset();
  endtask

  task automatic test_priority();
    apply_reset();
    prio_arr[5] = 3; prio_arr[9] = 6;
    irq_pending_i[5] = 1; irq_pending_i[9] = 1;
    #1;
    tests++;
    if (claim_valid_o !== 0) begin
      fails++; $display("FAIL prio_no_early_valid: got %0b want 0", claim_valid_o);
    end
    tick();
    check_offer("prio_winner", 9, 6);
  endtask

  task automatic test_round_robin();
    int exp_ids[4] = '{2, 7, 12, 2};
    apply_reset();
    prio_arr[2] = 4; prio_arr[7] = 4; prio_arr[12] = 4;
    irq_pending_i[2] = 1; irq_pending_i[7] = 1; irq_pending_i[12] = 1;
    tick();
    for (int r = 0; r < 4; r++) begin
      check_offer($sformatf("rr_round%0d", r), exp_ids[r], 4);
      do_claim();
      tests++;
      if (claim_valid_o !== 0 || in_service_o !== 1) begin
        fails++;
        $display("FAIL rr_claim%0d: valid=%0b insvc=%0b want 0/1", r, claim_valid_o, in_service_o);
      end
      do_eoi(exp_ids[r]);
      tick();
    end
  endtask

  task automatic test_threshold();
    apply_reset();
    prio_arr[3] = 2; irq_pending_i[3] = 1; threshold_i = 2;
    repeat (4) tick();
    tests++;
    if (claim_valid_o !== 0) begin
      fails++; $display("FAIL thresh_block: valid=%0b want 0", claim_valid_o);
    end
    threshold_i = 1;
    tick();
    check_offer("thresh_pass", 3, 2);
  endtask

  task automatic test_hold();
    apply_reset();
    prio_arr[1] = 2; irq_pending_i[1] = 1;
    tick();
    check_offer("hold_initial", 1, 2);
    prio_arr[20] = 7; irq_pending_i[20] = 1; irq_pending_i[1] = 0; threshold_i = 5;
    for (int c = 0; c < 10; c++) begin
      tick();
      check_offer($sformatf("hold_cycle%0d", c), 1, 2);
    end
    threshold_i = 0;
    do_claim(); do_eoi(1); tick();
    check_offer("hold_next", 20, 7);
  endtask

  task automatic test_bad_eoi();
    apply_reset();
    do_eoi(3);
    tests++;
    if (err_o !== 1) begin fails++; $display("FAIL eoi_idle_err: err=%0b want 1", err_o); end
    prio_arr[6] = 5; irq_pending_i[6] = 1;
    tick();
    check_offer("eoi_offer", 6, 5);
    do_claim(); irq_pending_i[6] = 0;
    do_eoi(4);
    tests++;
    if (err_o !== 1 || in_service_o !== 1) begin
      fails++; $display("FAIL eoi_mismatch: err=%0b insvc=%0b want 1/1", err_o, in_service_o);
    end
    tick();
    tests++;
    if (err_o !== 0 || in_service_o !== 1) begin
      fails++; $display("FAIL eoi_pulse_end: err=%0b insvc=%0b want 0/1", err_o, in_service_o);
    end
    do_eoi(6);
    tests++;
    if (err_o !== 0 || in_service_o !== 0) begin
      fails++; $display("FAIL eoi_match: err=%0b insvc=%0b want 0/0", err_o, in_service_o);
    end
  endtask

  task automatic test_async_reset();
    apply_reset();
    prio_arr[8] = 6; irq_pending_i[8] = 1;
    tick();
    check_offer("arst_offer", 8, 6);
    #2 rst_i = 1; #1;
    tests++;
    if (claim_valid_o !== 0 || claim_id_o !== 0 || claim_prio_o !== 0 ||
        in_service_o !== 0 || err_o !== 0) begin
      fails++;
      $display("FAIL arst_outputs: valid=%0b id=%0d prio=%0d insvc=%0b err=%0b want all 0",
               claim_valid_o, claim_id_o, claim_prio_o, in_service_o, err_o);
    end
    tick();
    clear_inputs(); rst_i = 0; model_rr = N - 1;
    prio_arr[0] = 3; prio_arr[1] = 3; irq_pending_i[0] = 1; irq_pending_i[1] = 1;
    tick();
    check_offer("arst_tie", 0, 3);
  endtask

  task automatic test_random();
    bit any; int id, pr, wait_cnt;
    apply_reset();
    for (int it = 0; it < 60; it++) begin
      irq_pending_i = $urandom; irq_enable_i = $urandom;
      if ($urandom_range(0, 3) == 0) irq_pending_i = irq_pending_i & 32'h0000_0410;
      threshold_i = PW'($urandom_range(0, 3));
      for (int n = 0; n < N; n++) prio_arr[n] = $urandom_range(0, 7);
      model_winner(model_rr, any, id, pr);
      tick();
      if (!any) begin
        tests++;
        if (claim_valid_o !== 0) begin
          fails++; $display("FAIL rand%0d_none: valid=%0b want 0", it, claim_valid_o);
        end
        continue;
      end
      check_offer($sformatf("rand%0d", it), id, pr);
      wait_cnt = $urandom_range(0, 3);
      repeat (wait_cnt) tick();
      do_claim();
      if ($urandom_range(0, 1) == 1) begin
        do_eoi((id + 1) % N);
        tests++;
        if (err_o !== 1) begin fails++; $display("FAIL rand%0d_bad_eoi: err=%0b want 1", it, err_o); end
      end
      do_eoi(id);
      tests++;
      if (in_service_o !== 0) begin
        fails++; $display("FAIL rand%0d_eoi: insvc=%0b want 0", it, in_service_o);
      end
    end
  endtask

  initial begin
    test_reset();
    test_priority();
    test_round_robin();
    test_threshold();
    test_hold();
    test_bad_eoi();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
